// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types and helpers for the programmable clock divider
package clkdiv_pkg;

    typedef enum logic [1:0] {ST_SYNC, ST_HOLD, ST_WRAP, ST_COUNT} step_t;

    localparam int MAX_W = 64;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_W-1:0] clamp1(input logic [MAX_W-1:0] v);
        return (v == '0) ? MAX_W'(1) : v;
    endfunction

    function automatic bit div_ok(input longint unsigned d, input int w);
        return d >= 1 && (w >= 64 || d < (64'd1 << w));
    endfunction

endpackage

// File: rtl/div_channel.sv
// div_channel: one divider channel with shadowed divisor applied on wrap
module div_channel
    import clkdiv_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DEF_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [WIDTH-1:0] load_div,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] shadow;
    step_t            step;

    // Sync outranks enable; a wrap happens on the last count of the period
    always_comb step = sync ? ST_SYNC : !en ? ST_HOLD : (count == div - WIDTH'(1)) ? ST_WRAP : ST_COUNT;

    // Counter, divided clock and tick; new divisor only takes effect at a wrap
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            count   <= '0;
            div     <= DEF_DIV;
            shadow  <= '0;
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= step == ST_WRAP;
            case (step)
                ST_SYNC: begin
                    count   <= '0;
                    clk_out <= 1'b0;
                end
                ST_HOLD: ;
                ST_WRAP: begin
                    count   <= '0;
                    clk_out <= ~clk_out;
                    if (pending) begin
                        div     <= shadow;
                        pending <= 1'b0;
                    end
                end
                default: count <= count + WIDTH'(1);
            endcase
            if (load) begin
                shadow  <= load_div;
                pending <= 1'b1;
            end
        end

endmodule

// File: rtl/prog_clock_divider.sv
// prog_clock_divider: multi-channel programmable divider with divisor load handshake
module prog_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int              CHANNELS = 4,
    parameter int              WIDTH    = 32,
    parameter longint unsigned DEF_DIV  = 250000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          en,
    input  logic                         sync,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [idx_w(CHANNELS)-1:0]   load_ch,
    input  logic [WIDTH-1:0]             load_div,
    output logic                         load_err,
    output logic [CHANNELS-1:0]          pending,
    output logic [CHANNELS-1:0]          clk_out,
    output logic [CHANNELS-1:0]          tick
);

    localparam int CH_IDX_W = idx_w(CHANNELS);
    localparam int PW       = 2 ** CH_IDX_W;

    logic             in_range;
    logic [PW-1:0]    pend_ext;
    logic [WIDTH-1:0] new_div;

    if (!div_ok(DEF_DIV, WIDTH)) begin : g_bad_def
        $error("DEF_DIV must be in 1 .. 2^WIDTH-1");
    end

    // Padding pending to a power of two keeps out-of-range indexing defined
    assign pend_ext   = PW'(pending);
    assign in_range   = int'(load_ch) < CHANNELS;
    assign load_ready = in_range && !pend_ext[load_ch];
    assign new_div    = WIDTH'(clamp1(MAX_W'(load_div)));

    // Flag a write aimed at a channel that does not exist
    always_ff @(posedge clk or negedge rst)
        if (!rst) load_err <= 1'b0;
        else      load_err <= load_valid && !in_range;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        div_channel #(
            .WIDTH   (WIDTH),
            .DEF_DIV (WIDTH'(DEF_DIV))
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en[c]),
            .sync     (sync),
            .load     (load_valid && load_ready && load_ch == CH_IDX_W'(c)),
            .load_div (new_div),
            .pending  (pending[c]),
            .clk_out  (clk_out[c]),
            .tick     (tick[c])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// tb_prog_clock_divider: directed checks of divide, load handshake, enable, sync and reset
module tb_prog_clock_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] en;
    logic       sync;
    logic       lv;
    logic       lready;
    logic [0:0] lch;
    logic [7:0] ldiv;
    logic       lerr;
    logic [1:0] pend;
    logic [1:0] co;
    logic [1:0] tk;

    logic [2:0] en3;
    logic       sync3;
    logic       lv3;
    logic       ready3;
    logic [1:0] lch3;
    logic [7:0] ldiv3;
    logic       err3;
    logic [2:0] pend3;
    logic [2:0] co3;
    logic [2:0] tk3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prog_clock_divider #(.CHANNELS(2), .WIDTH(8), .DEF_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .load_valid(lv), .load_ready(lready),
        .load_ch(lch), .load_div(ldiv), .load_err(lerr), .pending(pend), .clk_out(co), .tick(tk)
    );

    prog_clock_divider #(.CHANNELS(3), .WIDTH(8), .DEF_DIV(4)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .sync(sync3), .load_valid(lv3), .load_ready(ready3),
        .load_ch(lch3), .load_div(ldiv3), .load_err(err3), .pending(pend3), .clk_out(co3), .tick(tk3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 2'b00; sync = 1'b0; lv = 1'b0; lch = 1'b0; ldiv = 8'd0;
        en3 = 3'b000; sync3 = 1'b0; lv3 = 1'b0; lch3 = 2'd0; ldiv3 = 8'd0;
        #1 rst = 1'b0;
        #2;
        chk("rst_clk_out", co, 2'b00);
        chk("rst_tick", tk, 2'b00);
        chk("rst_pending", pend, 2'b00);
        chk("rst_load_err", lerr, 1'b0);
        chk("rst_load_ready", lready, 1'b1);
        en = 2'b11;
        #9 rst = 1'b1;
        // divide by the reset divisor of 4
        step(3);
        chk("e3_tick", tk, 2'b00);
        chk("e3_clk_out", co, 2'b00);
        step(1);
        chk("e4_tick", tk, 2'b11);
        chk("e4_clk_out", co, 2'b11);
        step(1);
        chk("e5_tick", tk, 2'b00);
        chk("e5_clk_out", co, 2'b11);
        step(3);
        chk("e8_tick", tk, 2'b11);
        chk("e8_clk_out", co, 2'b00);
        chk("u3_idle", {tk3, co3}, 6'b0);
        // load ch0 div=2 mid-period
        step(1);
        lv = 1'b1; lch = 1'b0; ldiv = 8'd2;
        #1 chk("ld0_ready", lready, 1'b1);
        step(1);
        lv = 1'b0;
        chk("ld0_pending", pend, 2'b01);
        #1 chk("ld0_busy", lready, 1'b0);
        step(1);
        chk("e11_tick", tk, 2'b00);
        step(1);
        chk("e12_tick", tk, 2'b11);
        chk("e12_pending", pend, 2'b00);
        chk("e12_clk_out", co, 2'b11);
        step(2);
        chk("e14_tick", tk, 2'b01);
        chk("e14_clk_out", co, 2'b10);
        step(2);
        chk("e16_tick", tk, 2'b11);
        chk("e16_clk_out", co, 2'b01);
        // load ch1 div=0, clamped to 1
        lv = 1'b1; lch = 1'b1; ldiv = 8'd0;
        #1 chk("ld1_ready", lready, 1'b1);
        step(1);
        lv = 1'b0;
        chk("ld1_pending", pend, 2'b10);
        step(3);
        chk("e20_tick", tk, 2'b11);
        chk("e20_pending", pend, 2'b00);
        step(1);
        chk("e21_tick", tk, 2'b10);
        chk("e21_clk_out", co, 2'b01);
        step(1);
        chk("e22_tick", tk, 2'b11);
        chk("e22_clk_out", co, 2'b10);
        // out-of-range channel on the 3-channel instance
        lv3 = 1'b1; lch3 = 2'd3; ldiv3 = 8'd5;
        #1 chk("bad_ready", ready3, 1'b0);
        step(1);
        lv3 = 1'b0;
        chk("bad_err", err3, 1'b1);
        chk("bad_pending", pend3, 3'b000);
        chk("main_no_err", lerr, 1'b0);
        step(1);
        chk("bad_err_once", err3, 1'b0);
        lch3 = 2'd2;
        #1 chk("ch2_ready", ready3, 1'b1);
        // reload both channels to 4, including a stalled request
        lv = 1'b1; lch = 1'b0; ldiv = 8'd4;
        #1 chk("rl0_ready", lready, 1'b1);
        step(1);
        chk("rl0_pending", pend, 2'b01);
        ldiv = 8'd7;
        #1 chk("stall_ready", lready, 1'b0);
        step(1);
        lv = 1'b0;
        chk("stall_pending", pend, 2'b00);
        chk("stall_no_err", lerr, 1'b0);
        lv = 1'b1; lch = 1'b1; ldiv = 8'd4;
        #1 chk("rl1_ready", lready, 1'b1);
        step(1);
        lv = 1'b0;
        chk("rl1_pending", pend, 2'b10);
        step(1);
        chk("rl1_applied", pend, 2'b00);
        // align, then freeze ch0 for five edges
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        chk("sync_clk_out", co, 2'b00);
        chk("sync_tick", tk, 2'b00);
        step(2);
        en = 2'b10;
        step(2);
        chk("hold_s4_tick", tk, 2'b10);
        chk("hold_s4_clk_out", co, 2'b10);
        step(3);
        chk("hold_s7_tick", tk, 2'b00);
        chk("hold_s7_clk_out", co, 2'b10);
        en = 2'b11;
        step(1);
        chk("resume_s8_tick", tk, 2'b10);
        chk("resume_s8_clk_out", co, 2'b00);
        step(1);
        chk("resume_s9_tick", tk, 2'b01);
        chk("resume_s9_clk_out", co, 2'b01);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        chk("sync2_clk_out", co, 2'b00);
        chk("sync2_tick", tk, 2'b00);
        step(3);
        chk("sync2_3_tick", tk, 2'b00);
        step(1);
        chk("sync2_4_tick", tk, 2'b11);
        chk("sync2_4_clk_out", co, 2'b11);
        // async reset with ch0 pending
        lv = 1'b1; lch = 1'b0; ldiv = 8'd2;
        step(1);
        lv = 1'b0;
        chk("pre_rst_pending", pend, 2'b01);
        #3 rst = 1'b0;
        #1;
        chk("arst_clk_out", co, 2'b00);
        chk("arst_tick", tk, 2'b00);
        chk("arst_pending", pend, 2'b00);
        #3 rst = 1'b1;
        step(2);
        chk("post_rst_e2_tick", tk, 2'b00);
        step(2);
        chk("post_rst_e4_tick", tk, 2'b11);
        chk("post_rst_pending", pend, 2'b00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
